node_report_tx: RTL and testbench
=================================

NODE_REPORT_TX -- requirements
Module: node_report_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, gives clk cycles per UART bit (50 MHz / 115200 baud); legal range is 2 to 65535.
REQ-002 clk  input  1  single system clock; all logic on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 node_valid  input  1  node-detection event request from the line-follower controller.
REQ-005 node_side  input  1  side of the detected node: 0 = left, 1 = right; sampled with node_valid.
REQ-006 node_ready  output  1  block can accept an event this cycle.
REQ-007 tx  output  1  UART serial line to the XBee; idles high.
REQ-008 busy  output  1  a frame is in transmission.
REQ-009 node_count  output  8  running count of accepted node events.

Function
REQ-010 An event is accepted on a posedge where node_valid=1 and node_ready=1; node_side is captured on that edge.
REQ-011 node_ready shall be 1 only in IDLE and shall equal ~busy; node_valid while busy is ignored, and no event is queued.
REQ-012 On acceptance, node_count shall increment by 1, modulo 256, so 255 wraps to 0.
REQ-013 Each accepted event produces one 4-byte frame, sent back-to-back:
- byte0 = 0x4E ('N')
- byte1 = 0x4C ('L') for side 0, or 0x52 ('R') for side 1
- byte2 = the post-increment node_count
- byte3 = byte0 XOR byte1 XOR byte2
REQ-014 Frame bytes shall be latched at acceptance; later changes to the inputs shall not alter a frame in flight.
REQ-015 Each byte is UART 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1); each bit holds for exactly CLKS_PER_BIT cycles.
REQ-016 The FSM has states IDLE, START, DATA, STOP, with these transitions:
- IDLE -> START on acceptance.
- START -> DATA after CLKS_PER_BIT cycles.
- DATA -> STOP after 8 bits.
- STOP -> START if byte index < 3, incrementing the index; STOP -> IDLE if byte index = 3.
REQ-017 tx shall go low on the cycle after the acceptance edge, registered with zero extra latency.
REQ-018 There is no idle gap between bytes: the start bit of the next byte immediately follows the previous stop bit.
REQ-019 busy shall be 1 from the cycle after acceptance through the last stop-bit cycle of byte3, a total of exactly 40*CLKS_PER_BIT cycles.
REQ-020 node_ready shall return to 1 on the first cycle after the byte3 stop bit ends, so the earliest next start bit begins 40*CLKS_PER_BIT+1 cycles after the previous acceptance.
REQ-021 tx shall be driven from a register and shall be glitch-free.
REQ-022 In IDLE, tx shall be 1.

Reset
REQ-023 While rst=1 on a posedge, the next-cycle outputs shall be tx=1, busy=0, node_ready=1, node_count=0, with the FSM in IDLE, byte index 0, and bit and baud counters 0.
REQ-024 Reset asserted mid-frame shall abandon the frame immediately: tx returns to 1 on the next cycle, with no completion of the current bit or byte.
REQ-025 node_valid=1 coincident with rst=1 shall not be accepted and shall not increment node_count.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-026 Reset, then one left event: line decodes as 0x4E 0x4C 0x01 0x03; node_count=1; busy high for exactly 160 cycles.
REQ-027 Second event, right side: line decodes as 0x4E 0x52 0x02 0x1E; tx low on the cycle after acceptance.
REQ-028 node_valid held high continuously for 3 frames: exactly 3 frames with counts 1, 2, 3; each new start bit occurs 161 cycles after the previous acceptance; no event is accepted while busy.
REQ-029 256 accepted events: the 256th frame carries count 0x00 and checksum 0x4E^side_byte; node_count reads 0.
REQ-030 Assert rst during byte2, bit 3: tx=1, busy=0, node_count=0 on the next cycle; the following event sends count 0x01.
REQ-031 CLKS_PER_BIT=2 boundary: every bit width measured on tx is exactly 2 cycles, and the frame spans 80 cycles.

Source files
------------

// File: rtl/node_report_tx.sv
// Node-detection reporter: each accepted event is sent as a 4-byte UART 8N1 frame
// ('N', side, count, xor checksum) to the XBee link.
module node_report_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       node_valid,
  input  logic       node_side,
  output logic       node_ready,
  output logic       tx,
  output logic       busy,
  output logic [7:0] node_count,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  // Handshake: an event transfers on a posedge where node_valid && node_ready;
  // node_ready is high only in IDLE, and requests seen while busy are dropped.

  state_t          state, state_nx;
  logic [15:0]     baud_cnt, baud_nx;
  logic [2:0]      bit_idx, bit_nx;
  logic [1:0]      byte_idx, byte_nx;
  logic            tx_q, tx_nx;
  logic [3:0][7:0] frame;
  logic [7:0]      count_q;

  logic       accept;
  logic       bit_done;
  logic [7:0] cur_byte;
  logic [2:0] bit_inc;
  logic [7:0] count_inc;
  logic [7:0] side_byte;

  assign accept    = node_valid && (state == S_IDLE);
  assign bit_done  = (baud_cnt == BAUD_LAST);
  assign cur_byte  = frame[byte_idx];
  assign bit_inc   = bit_idx + 3'd1;
  assign count_inc = count_q + 8'd1;
  assign side_byte = node_side ? 8'h52 : 8'h4C;

  always_comb begin
    state_nx = state;
    baud_nx  = baud_cnt;
    bit_nx   = bit_idx;
    byte_nx  = byte_idx;
    tx_nx    = tx_q;
    case (state)
      S_IDLE: begin
        tx_nx   = 1'b1;
        baud_nx = '0;
        bit_nx  = '0;
        byte_nx = '0;
        if (node_valid) begin
          state_nx = S_START;
          tx_nx    = 1'b0;
        end
      end
      S_START: begin
        if (bit_done) begin
          baud_nx  = '0;
          state_nx = S_DATA;
          tx_nx    = cur_byte[0];
        end else begin
          baud_nx = baud_cnt + 16'd1;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          baud_nx = '0;
          if (bit_idx == 3'd7) begin
            bit_nx   = '0;
            state_nx = S_STOP;
            tx_nx    = 1'b1;
          end else begin
            bit_nx = bit_inc;
            tx_nx  = cur_byte[bit_inc];
          end
        end else begin
          baud_nx = baud_cnt + 16'd1;
        end
      end
      S_STOP: begin
        if (bit_done) begin
          baud_nx = '0;
          if (byte_idx == 2'd3) begin
            byte_nx  = '0;
            state_nx = S_IDLE;
            tx_nx    = 1'b1;
          end else begin
            // next start bit follows the stop bit with no idle gap
            byte_nx  = byte_idx + 2'd1;
            state_nx = S_START;
            tx_nx    = 1'b0;
          end
        end else begin
          baud_nx = baud_cnt + 16'd1;
        end
      end
      default: begin
        state_nx = S_IDLE;
        tx_nx    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      tx_q     <= 1'b1;
      frame    <= '0;
      count_q  <= '0;
    end else begin
      state    <= state_nx;
      baud_cnt <= baud_nx;
      bit_idx  <= bit_nx;
      byte_idx <= byte_nx;
      tx_q     <= tx_nx;
      if (accept) begin
        // whole frame captured here so input changes cannot disturb it in flight
        frame   <= {8'h4E ^ side_byte ^ count_inc, count_inc, side_byte, 8'h4E};
        count_q <= count_inc;
      end
    end
  end

  assign tx         = tx_q;
  assign busy       = (state != S_IDLE);
  assign node_ready = ~busy;
  assign node_count = count_q;
  assign dbg_state  = state;

endmodule

// File: tb/tb_node_report_tx.sv
// Bench for node_report_tx: a cycle model of acceptance/count, a queue of expected
// line bytes, and a tx decoder that checks every bit cycle against the expected byte.
module tb_node_report_tx;

  localparam int CPB  = 4;
  localparam int CPB2 = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, node_valid, node_side;
  logic       node_ready, tx, busy;
  logic [7:0] node_count;
  logic [1:0] dbg_state;

  logic       v2, s2;
  logic       ready2, tx2, busy2;
  logic [7:0] count2;
  logic [1:0] dbg2;

  node_report_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .node_valid(node_valid), .node_side(node_side),
    .node_ready(node_ready), .tx(tx), .busy(busy), .node_count(node_count),
    .dbg_state(dbg_state)
  );

  node_report_tx #(.CLKS_PER_BIT(CPB2)) dut2 (
    .clk(clk), .rst(rst), .node_valid(v2), .node_side(s2),
    .node_ready(ready2), .tx(tx2), .busy(busy2), .node_count(count2),
    .dbg_state(dbg2)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  int cyc = 0;
  int mdl_left = 0;
  logic [7:0] mdl_count = 8'd0;
  int acc_cnt = 0;
  int last_acc_cyc = 0;
  logic [7:0] exp_q[$];
  bit started = 0, cont_mode = 0, have_prev = 0, rx_active = 0;
  int prev_start = 0;
  int rx_pos = 0;
  int busy_run = 0;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      if (failures <= 30) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model of acceptance, count and busy window
  always @(posedge clk) begin
    logic [7:0] b1;
    cyc++;
    if (rst) begin
      mdl_left  = 0;
      mdl_count = 8'd0;
      exp_q.delete();
    end else if (mdl_left > 0) begin
      mdl_left--;
    end else if (node_valid === 1'b1) begin
      mdl_count = mdl_count + 8'd1;
      b1 = node_side ? 8'h52 : 8'h4C;
      exp_q.push_back(8'h4E);
      exp_q.push_back(b1);
      exp_q.push_back(mdl_count);
      exp_q.push_back(8'h4E ^ b1 ^ mdl_count);
      mdl_left = 40 * CPB;
      acc_cnt++;
      last_acc_cyc = cyc;
    end
  end

  // per-cycle handshake / count checks and busy window length
  always @(negedge clk) begin
    if (started) begin
      check("ready", node_ready, mdl_left == 0);
      check("busy", busy, mdl_left != 0);
      check("node_count", node_count, mdl_count);
      if (rst) busy_run = 0;
      else if (busy) busy_run++;
      else if (busy_run != 0) begin
        check("busy_cycles", busy_run, 40 * CPB);
        busy_run = 0;
      end
    end
  end

  // ---------------- tx decoder ----------------
  task automatic rx_byte();
    logic [7:0] e;
    logic [9:0] expb, got;
    int errs;
    errs = 0;
    got = '0;
    rx_active = 1;
    if (exp_q.size() == 0) begin
      check("rx_unexpected_frame", 1, 0);
      e = 8'h00;
    end else begin
      e = exp_q.pop_front();
    end
    if (rx_pos == 0) begin
      check("start_latency", cyc - last_acc_cyc, 0);
      if (cont_mode && have_prev) check("start_gap", cyc - prev_start, 40 * CPB + 1);
      prev_start = cyc;
      have_prev = 1;
    end
    expb = {1'b1, e, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < CPB; c++) begin
        if (i != 0 || c != 0) @(negedge clk);
        if (rst) begin
          rx_pos = 0;
          rx_active = 0;
          return;
        end
        if (tx !== expb[i]) errs++;
        if (c == CPB / 2) got[i] = tx;
      end
    end
    check("rx_byte", got[8:1], e);
    check("bit_timing", errs, 0);
    rx_pos = (rx_pos + 1) % 4;
    rx_active = 0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (started && !rst && tx === 1'b0) rx_byte();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic side);
    node_valid = 1'b1;
    node_side  = side;
    @(posedge clk);
    #1;
    node_valid = 1'b0;
    node_side  = ~side;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((mdl_left != 0 || exp_q.size() != 0 || rx_active) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check("idle_timeout", n >= 2000, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    node_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    node_valid = 1'b0;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_ready", node_ready, 1);
    check("rst_count", node_count, 0);
    check("rst_state", dbg_state, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] fb [4];
    logic [9:0] bits10;
    logic [79:0] obs, exp80;
    int bc, base, n;

    rst = 1'b1; node_valid = 1'b1; node_side = 1'b0; v2 = 1'b0; s2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; node_valid = 1'b0;
    started = 1;
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_ready", node_ready, 1);
    check("rst_count_valid_in_reset", node_count, 0);

    // single left then right event
    send(1'b0);
    wait_idle();
    check("count_after_left", node_count, 1);
    send(1'b1);
    wait_idle();
    check("count_after_right", node_count, 2);

    // valid held high across 256 frames, side changing every cycle
    do_reset();
    have_prev = 0;
    cont_mode = 1;
    node_valid = 1'b1;
    base = acc_cnt;
    n = 0;
    while (acc_cnt - base < 256 && n < 50000) begin
      @(posedge clk);
      #1;
      node_side = 1'($urandom_range(0, 1));
      n++;
    end
    node_valid = 1'b0;
    check("cont_timeout", n >= 50000, 0);
    wait_idle();
    cont_mode = 0;
    check("count_wrap", node_count, 0);

    // reset during byte2, data bit 3
    send(1'b0);
    repeat (24 * CPB) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_tx", tx, 1);
    check("midrst_busy", busy, 0);
    check("midrst_count", node_count, 0);
    send(1'b1);
    wait_idle();
    check("count_after_midrst", node_count, 1);

    // CLKS_PER_BIT=2 instance: every bit exactly 2 cycles, 80-cycle frame
    fb[0] = 8'h4E; fb[1] = 8'h52; fb[2] = 8'h01; fb[3] = 8'h1D;
    exp80 = '0;
    for (int b = 0; b < 4; b++) begin
      bits10 = {1'b1, fb[b], 1'b0};
      for (int i = 0; i < 10; i++)
        for (int c = 0; c < CPB2; c++) exp80[b * 20 + i * 2 + c] = bits10[i];
    end
    obs = '0;
    bc = 0;
    v2 = 1'b1; s2 = 1'b1;
    @(posedge clk);
    #1;
    v2 = 1'b0; s2 = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      obs[k] = tx2;
      if (busy2) bc++;
    end
    check("cpb2_frame", obs, exp80);
    check("cpb2_busy_cycles", bc, 80);
    @(negedge clk);
    check("cpb2_after", {tx2, busy2, ready2}, 3'b101);
    check("cpb2_count", count2, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
